// File: rtl/svm_pkg.sv
// Shared types and constants for the SVM score-to-probability mapper.
// The stage record carries one score through the binary-search pipeline.
package svm_pkg;

    localparam int SVM_SCORE_W   = 44;
    localparam int SVM_PROB_W    = 16;
    localparam int SVM_LOG2_BINS = 6;
    localparam int SVM_BINS      = 1 << SVM_LOG2_BINS;

    typedef logic signed [SVM_SCORE_W-1:0] score_t;
    typedef logic        [SVM_PROB_W-1:0]  prob_t;
    typedef logic        [SVM_LOG2_BINS-1:0] bin_t;

    localparam prob_t PROB_ONE = prob_t'(1) << (SVM_PROB_W - 1);

    typedef struct packed {
        logic   valid;
        logic   mode;
        bin_t   bin;
        score_t score;
    } stage_rec_t;

    // LUT entries above ONE are legal; their complement clamps at zero.
    function automatic prob_t complement_sat(input prob_t p);
        return (p > PROB_ONE) ? prob_t'(0) : prob_t'(PROB_ONE - p);
    endfunction

endpackage

// File: rtl/svm_search_stage.sv
// One registered step of the MSB-first binary search over the threshold table.
// Stage STAGE decides bit (LOG2_BINS-1-STAGE) of the bin index.
module svm_search_stage
    import svm_pkg::*;
#(
    parameter int STAGE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  score_t     thr [SVM_BINS-1],
    input  stage_rec_t in_rec,
    output stage_rec_t out_rec
);

    localparam int BIT = SVM_LOG2_BINS - 1 - STAGE;

    bin_t       cand;
    bin_t       thr_idx;
    score_t     sel_thr;
    stage_rec_t rec_d;
    stage_rec_t rec_q;

    // Lower bits of the incoming bin are still zero, so cand-1 is the threshold
    // that separates the two halves of the remaining range.
    always_comb begin
        cand    = in_rec.bin | (bin_t'(1) << BIT);
        thr_idx = cand - bin_t'(1);
        sel_thr = thr[thr_idx];
        rec_d   = in_rec;
        if ($signed(in_rec.score) > $signed(sel_thr)) begin
            rec_d.bin = cand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_q <= '0;
        end else if (en) begin
            rec_q <= rec_d;
        end
    end

    assign out_rec = rec_q;

endmodule

// File: rtl/svm_prob_mapper.sv
// Programmable SVM score to probability mapper: pipelined binary search over a
// run-time threshold table, then a probability LUT and optional complement.
module svm_prob_mapper
    import svm_pkg::*;
#(
    parameter int SCORE_W   = SVM_SCORE_W,
    parameter int PROB_W    = SVM_PROB_W,
    parameter int LOG2_BINS = SVM_LOG2_BINS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [SCORE_W-1:0]   s_score,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PROB_W-1:0]    m_prob,
    output logic [LOG2_BINS-1:0] m_bin,
    input  logic                 mode,
    input  logic                 cfg_we,
    input  logic                 cfg_sel,
    input  logic [LOG2_BINS-1:0] cfg_addr,
    input  logic [SCORE_W-1:0]   cfg_data,
    output logic                 cfg_ready
);

    score_t     thr_q [SVM_BINS-1];
    score_t     thr_d [SVM_BINS-1];
    prob_t      lut_q [SVM_BINS];
    prob_t      lut_d [SVM_BINS];

    stage_rec_t head_rec;
    stage_rec_t stage_out [SVM_LOG2_BINS];

    logic       en;
    logic       any_valid;
    logic       cfg_commit;

    logic       lut_valid_q, lut_valid_d;
    logic       lut_mode_q,  lut_mode_d;
    bin_t       lut_bin_q,   lut_bin_d;
    prob_t      lut_prob_q,  lut_prob_d;

    logic       m_valid_q, m_valid_d;
    prob_t      m_prob_q,  m_prob_d;
    bin_t       m_bin_q,   m_bin_d;

    assign en         = !m_valid_q || m_ready;
    assign s_ready    = en && !cfg_we;
    assign cfg_ready  = !any_valid && !m_valid_q;
    assign cfg_commit = cfg_we && cfg_ready;

    always_comb begin
        any_valid = lut_valid_q;
        for (int k = 0; k < SVM_LOG2_BINS; k++) begin
            any_valid = any_valid | stage_out[k].valid;
        end
    end

    always_comb begin
        head_rec       = '0;
        head_rec.valid = s_valid && s_ready;
        head_rec.mode  = mode;
        head_rec.score = score_t'(s_score);
    end

    for (genvar k = 0; k < SVM_LOG2_BINS; k++) begin : g_stage
        if (k == 0) begin : g_first
            svm_search_stage #(.STAGE(k)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en),
                .thr     (thr_q),
                .in_rec  (head_rec),
                .out_rec (stage_out[k])
            );
        end else begin : g_next
            svm_search_stage #(.STAGE(k)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en),
                .thr     (thr_q),
                .in_rec  (stage_out[k-1]),
                .out_rec (stage_out[k])
            );
        end
    end

    // The last address of the threshold table has no backing entry and is ignored.
    always_comb begin
        thr_d = thr_q;
        lut_d = lut_q;
        if (cfg_commit) begin
            if (!cfg_sel) begin
                if (bin_t'(cfg_addr) != bin_t'(SVM_BINS - 1)) begin
                    thr_d[cfg_addr] = score_t'(cfg_data);
                end
            end else begin
                lut_d[cfg_addr] = cfg_data[SVM_PROB_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_q <= '{default: '0};
            lut_q <= '{default: '0};
        end else begin
            thr_q <= thr_d;
            lut_q <= lut_d;
        end
    end

    always_comb begin
        lut_valid_d = stage_out[SVM_LOG2_BINS-1].valid;
        lut_mode_d  = stage_out[SVM_LOG2_BINS-1].mode;
        lut_bin_d   = stage_out[SVM_LOG2_BINS-1].bin;
        lut_prob_d  = lut_q[stage_out[SVM_LOG2_BINS-1].bin];
        m_valid_d   = lut_valid_q;
        m_bin_d     = lut_bin_q;
        m_prob_d    = lut_mode_q ? complement_sat(lut_prob_q) : lut_prob_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_valid_q <= 1'b0;
            lut_mode_q  <= 1'b0;
            lut_bin_q   <= '0;
            lut_prob_q  <= '0;
            m_valid_q   <= 1'b0;
            m_prob_q    <= '0;
            m_bin_q     <= '0;
        end else if (en) begin
            lut_valid_q <= lut_valid_d;
            lut_mode_q  <= lut_mode_d;
            lut_bin_q   <= lut_bin_d;
            lut_prob_q  <= lut_prob_d;
            m_valid_q   <= m_valid_d;
            m_prob_q    <= m_prob_d;
            m_bin_q     <= m_bin_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_prob  = PROB_W'(m_prob_q);
    assign m_bin   = LOG2_BINS'(m_bin_q);

endmodule

// File: tb/tb_svm_prob_mapper.sv
// Randomised bench for svm_prob_mapper against a counting reference model of
// the bin rule, with an in-order scoreboard of accepted scores.
module tb_svm_prob_mapper;

    localparam int SW = 44;
    localparam int PW = 16;
    localparam int LB = 6;
    localparam int NB = 64;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          s_valid  = 1'b0;
    logic          s_ready;
    logic [SW-1:0] s_score  = '0;
    logic          m_valid;
    logic          m_ready  = 1'b1;
    logic [PW-1:0] m_prob;
    logic [LB-1:0] m_bin;
    logic          mode     = 1'b0;
    logic          cfg_we   = 1'b0;
    logic          cfg_sel  = 1'b0;
    logic [LB-1:0] cfg_addr = '0;
    logic [SW-1:0] cfg_data = '0;
    logic          cfg_ready;

    svm_prob_mapper dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_score   (s_score),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_prob    (m_prob),
        .m_bin     (m_bin),
        .mode      (mode),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint bin;
        longint prob;
        longint acc_cycle;
        bit     chk_lat;
    } exp_t;

    exp_t          exp_q [$];
    longint        thr_m [NB-1];
    longint        lut_m [NB];
    int            errors       = 0;
    int            checks       = 0;
    longint        cycle        = 0;
    bit            rand_ready   = 1'b0;
    bit            lat_flag     = 1'b0;
    bit            last_acc     = 1'b0;
    bit            hold_pending = 1'b0;
    logic [PW-1:0] held_prob;
    logic [LB-1:0] held_bin;

    task automatic checkOutput(input string tag, input longint obs, input longint expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, expv, cycle);
        end
    endtask

    // Bin = how many thresholds the score strictly exceeds.
    function automatic longint model_bin(input longint sc);
        longint n = 0;
        for (int j = 0; j < NB - 1; j++) begin
            if (sc > thr_m[j]) n++;
        end
        return n;
    endfunction

    function automatic longint model_prob(input longint b, input bit md);
        longint l = lut_m[b];
        if (!md) return l;
        return (l > 32768) ? 0 : 32768 - l;
    endfunction

    task automatic clearModel();
        for (int j = 0; j < NB - 1; j++) thr_m[j] = 0;
        for (int j = 0; j < NB; j++) lut_m[j] = 0;
    endtask

    // One clock cycle: observe at the falling edge, then advance past the rising edge.
    task automatic tick();
        exp_t e;
        bit   pipe_empty;
        @(negedge clk);
        pipe_empty = (exp_q.size() == 0);
        checkOutput("cfg_ready", cfg_ready, pipe_empty);
        if (cfg_we) checkOutput("s_ready_during_cfg", s_ready, 0);
        if (pipe_empty) checkOutput("idle_m_valid", m_valid, 0);
        if (hold_pending) begin
            checkOutput("hold_valid", m_valid, 1);
            checkOutput("hold_prob", m_prob, held_prob);
            checkOutput("hold_bin", m_bin, held_bin);
        end
        hold_pending = m_valid && !m_ready;
        held_prob    = m_prob;
        held_bin     = m_bin;
        if (m_valid && m_ready) begin
            checkOutput("pop_has_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("bin", m_bin, e.bin);
                checkOutput("prob", m_prob, e.prob);
                if (e.chk_lat) checkOutput("latency", cycle - e.acc_cycle, 8);
            end
        end
        last_acc = s_valid && s_ready;
        if (last_acc) begin
            e.bin       = model_bin(longint'($signed(s_score)));
            e.prob      = model_prob(e.bin, mode);
            e.acc_cycle = cycle;
            e.chk_lat   = lat_flag;
            exp_q.push_back(e);
        end
        if (cfg_we && pipe_empty) begin
            if (!cfg_sel) begin
                if (cfg_addr != LB'(NB - 1)) thr_m[cfg_addr] = longint'($signed(cfg_data));
            end else begin
                lut_m[cfg_addr] = longint'(cfg_data[PW-1:0]);
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input longint sc, input bit md, input bit lat);
        int budget = 0;
        s_valid  = 1'b1;
        s_score  = SW'(sc);
        mode     = md;
        lat_flag = lat;
        do begin
            tick();
            budget++;
        end while (!last_acc && budget < 200);
        checkOutput("accepted", last_acc, 1);
        s_valid  = 1'b0;
        lat_flag = 1'b0;
    endtask

    task automatic cfgWrite(input bit sel, input int addr, input longint data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = LB'(addr);
        cfg_data = SW'(data);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic drainPipe();
        int budget = 0;
        while (exp_q.size() > 0 && budget < 400) begin
            tick();
            budget++;
        end
        checkOutput("drain", exp_q.size(), 0);
    endtask

    initial begin
        longint bnd [5] = '{-31000, -30999, 0, 31000, 31001};
        longint post [6] = '{0, 1, -1, -40000, 40000, 123456789};

        clearModel();
        #12;
        checkOutput("reset_m_valid", m_valid, 0);
        checkOutput("reset_m_prob", m_prob, 0);
        checkOutput("reset_m_bin", m_bin, 0);
        checkOutput("reset_s_ready", s_ready, 1);
        checkOutput("reset_cfg_ready", cfg_ready, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NB - 1; i++) cfgWrite(1'b0, i, longint'(i - 31) * 1000);
        for (int i = 0; i < NB; i++) cfgWrite(1'b1, i, longint'(i) * 512);
        cfgWrite(1'b0, NB - 1, -99999);

        $display("[TB] boundary scores");
        foreach (bnd[i]) begin
            applyStimulus(bnd[i], 1'b0, 1'b1);
            drainPipe();
        end

        $display("[TB] complement mode");
        applyStimulus(0, 1'b1, 1'b1);
        drainPipe();
        cfgWrite(1'b1, 31, 40000);
        applyStimulus(0, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 1'b0);
        drainPipe();

        $display("[TB] backpressure stream");
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(longint'($urandom_range(0, 70000)) - 35000, 1'($urandom_range(0, 1)), 1'b0);
        end
        drainPipe();
        rand_ready = 1'b0;
        m_ready    = 1'b1;

        $display("[TB] config gating");
        applyStimulus(-5000, 1'b0, 1'b0);
        cfgWrite(1'b0, 34, 2500);
        drainPipe();
        applyStimulus(3000, 1'b0, 1'b0);
        drainPipe();
        cfgWrite(1'b0, 34, 2500);
        applyStimulus(3000, 1'b0, 1'b0);
        drainPipe();

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(longint'($urandom_range(0, 60000)) - 30000, 1'b0, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_m_valid", m_valid, 0);
        checkOutput("midreset_s_ready", s_ready, 1);
        checkOutput("midreset_cfg_ready", cfg_ready, 1);
        checkOutput("midreset_m_prob", m_prob, 0);
        exp_q.delete();
        hold_pending = 1'b0;
        clearModel();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (10) tick();
        foreach (post[i]) applyStimulus(post[i], 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(longint'($urandom_range(0, 2000)) - 1000, 1'b0, 1'b0);
        end
        drainPipe();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
